// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the multi-cycle MUL/DIVU/REMU sequencer:
// ALU opcodes it drives, request op encodings and the FSM state type.
package alu_muldiv_seq_pkg;

    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REMU = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        MUL_STEP,
        DIV_CMP,
        DIV_SUB,
        DONE
    } state_t;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MUL (low word), DIVU and REMU built on a borrowed, externally
// arbitrated ALU: shift-add multiply and restoring division, one ALU op per grant.
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int size = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [size-1:0] req_a,
    input  logic [size-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [size-1:0] resp_result,
    output logic            busy,
    output logic            alu_req,
    input  logic            alu_gnt,
    output logic [size-1:0] alu_a,
    output logic [size-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    input  logic [size-1:0] alu_result
);

    localparam int cw = $clog2(size);
    localparam logic [cw-1:0] last_step = cw'(size - 1);

    state_t          state;
    logic [1:0]      op;
    logic [size-1:0] divisor;
    logic [size-1:0] acc, mcand, mplier;
    logic [size-1:0] rem, quo, dvd;
    logic            lt;
    logic [cw-1:0]   cnt;

    logic [size-1:0] sh, rem_next, quo_next, acc_next;

    assign sh       = {rem[size-2:0], dvd[size-1]};
    assign rem_next = lt ? rem : alu_result;
    assign quo_next = {quo[size-2:0], ~lt};
    assign acc_next = mplier[0] ? alu_result : acc;

    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign resp_valid = (state == DONE);
    assign alu_req    = (state == MUL_STEP) || (state == DIV_CMP) || (state == DIV_SUB);

    // Operands are a pure function of the state registers, so they hold
    // still through any number of ungranted cycles.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = ALU_NOP;
        case (state)
            MUL_STEP: begin
                alu_a    = acc;
                alu_b    = mcand;
                alu_ctrl = ALU_ADD;
            end
            DIV_CMP: begin
                alu_a    = sh;
                alu_b    = divisor;
                alu_ctrl = ALU_SLT;
            end
            DIV_SUB: begin
                alu_a    = rem;
                alu_b    = divisor;
                alu_ctrl = ALU_SUB;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op          <= OP_MUL;
            divisor     <= '0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            rem         <= '0;
            quo         <= '0;
            dvd         <= '0;
            lt          <= 1'b0;
            cnt         <= '0;
            resp_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op      <= req_op;
                        divisor <= req_b;
                        cnt     <= '0;
                        case (req_op)
                            OP_MUL: begin
                                acc    <= '0;
                                mcand  <= req_a;
                                mplier <= req_b;
                                state  <= MUL_STEP;
                            end
                            OP_DIVU, OP_REMU: begin
                                if (req_b == '0) begin
                                    resp_result <= (req_op == OP_DIVU) ? '1 : req_a;
                                    state       <= DONE;
                                end else begin
                                    rem   <= '0;
                                    quo   <= '0;
                                    dvd   <= req_a;
                                    state <= DIV_CMP;
                                end
                            end
                            OP_RSVD: begin
                                resp_result <= '0;
                                state       <= DONE;
                            end
                            default: ;
                        endcase
                    end
                end
                MUL_STEP: begin
                    if (alu_gnt) begin
                        acc    <= acc_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + cw'(1);
                        if (cnt == last_step) begin
                            resp_result <= acc_next;
                            state       <= DONE;
                        end
                    end
                end
                // A set rem MSB means the shifted value has 33 bits and cannot be below the divisor.
                DIV_CMP: begin
                    if (alu_gnt) begin
                        rem   <= sh;
                        dvd   <= dvd << 1;
                        lt    <= ~rem[size-1] & alu_result[0];
                        state <= DIV_SUB;
                    end
                end
                DIV_SUB: begin
                    if (alu_gnt) begin
                        rem <= rem_next;
                        quo <= quo_next;
                        cnt <= cnt + cw'(1);
                        if (cnt == last_step) begin
                            resp_result <= (op == OP_DIVU) ? quo_next : rem_next;
                            state       <= DONE;
                        end else begin
                            state <= DIV_CMP;
                        end
                    end
                end
                DONE: begin
                    if (resp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: models the shared ALU, scoreboards
// expected results per request and checks latency, stalls, reset and backpressure.
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_result;
    logic        busy;
    logic        alu_req;
    logic        alu_gnt = 1'b1;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;

    int checks = 0;
    int failures = 0;
    int lat = 0;
    logic [31:0] sb[$];

    logic [31:0] held_a, held_b;
    logic [3:0]  held_ctrl;
    logic [31:0] exp_val;

    alu_muldiv_seq #(.size(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .busy(busy), .alu_req(alu_req), .alu_gnt(alu_gnt),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    // External ALU; SLT compares unsigned, which the restoring divider relies on.
    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b0111: alu_result = {31'd0, alu_a < alu_b};
            default: alu_result = '0;
        endcase
    end

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00:   return a * b;
            2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        lat++;
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        #1;
        lat       = 1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_a     = '0;
        req_b     = '0;
        sb.push_back(model(op, a, b));
    endtask

    task automatic awaitResult(input string tag, input int exp_lat);
        while (!resp_valid && lat < 300) tick();
        checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
        if (sb.size() == 0) begin
            checkOutput({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            exp_val = sb.pop_front();
            checkOutput({tag, "_result"}, resp_result, exp_val);
        end
        tick();
        checkOutput({tag, "_idle_after_handshake"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        $display("[TB] start");
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_alu_req", {31'd0, alu_req}, 32'd0);
        checkOutput("reset_result", resp_result, 32'd0);
        checkOutput("reset_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);

        $display("[TB] multiply");
        applyStimulus(2'b00, 32'd7, 32'd6);
        awaitResult("mul_7x6", 33);
        applyStimulus(2'b00, 32'hFFFF_FFFF, 32'd2);
        awaitResult("mul_max_x2", 33);
        applyStimulus(2'b00, 32'h0001_0000, 32'h0001_0000);
        awaitResult("mul_wrap", 33);

        $display("[TB] divide");
        applyStimulus(2'b01, 32'd100, 32'd7);
        awaitResult("divu_100_7", 65);
        applyStimulus(2'b10, 32'd100, 32'd7);
        awaitResult("remu_100_7", 65);
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'h8000_0001);
        awaitResult("divu_big", 65);
        applyStimulus(2'b10, 32'hFFFF_FFFF, 32'h8000_0001);
        awaitResult("remu_big", 65);
        applyStimulus(2'b01, 32'hDEAD_BEEF, 32'h0000_1234);
        awaitResult("divu_misc", 65);

        $display("[TB] divide by zero and reserved op");
        applyStimulus(2'b01, 32'd5, 32'd0);
        checkOutput("divu_zero_alu_req", {31'd0, alu_req}, 32'd0);
        awaitResult("divu_by_zero", 1);
        applyStimulus(2'b10, 32'd5, 32'd0);
        checkOutput("remu_zero_alu_req", {31'd0, alu_req}, 32'd0);
        awaitResult("remu_by_zero", 1);
        applyStimulus(2'b11, 32'd9, 32'd3);
        awaitResult("reserved_op", 1);

        $display("[TB] grant stall");
        applyStimulus(2'b00, 32'd3, 32'd5);
        for (int i = 0; i < 4; i++) tick();
        alu_gnt   = 1'b0;
        held_a    = alu_a;
        held_b    = alu_b;
        held_ctrl = alu_ctrl;
        checkOutput("stall_ctrl_is_add", {28'd0, held_ctrl}, 32'h2);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("stall_alu_req", {31'd0, alu_req}, 32'd1);
            checkOutput("stall_alu_a", alu_a, held_a);
            checkOutput("stall_alu_b", alu_b, held_b);
            checkOutput("stall_alu_ctrl", {28'd0, alu_ctrl}, {28'd0, held_ctrl});
        end
        alu_gnt = 1'b1;
        awaitResult("mul_stalled", 43);

        $display("[TB] reset mid-divide");
        applyStimulus(2'b01, 32'd1000, 32'd3);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        checkOutput("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("midrst_alu_req", {31'd0, alu_req}, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);

        $display("[TB] response backpressure");
        resp_ready = 1'b0;
        applyStimulus(2'b00, 32'd2, 32'd2);
        while (!resp_valid && lat < 300) tick();
        checkOutput("bp_latency", 32'(lat), 32'd33);
        exp_val = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_valid_held", {31'd0, resp_valid}, 32'd1);
            checkOutput("bp_result_held", resp_result, exp_val);
        end
        resp_ready = 1'b1;
        tick();
        checkOutput("bp_valid_after_handshake", {31'd0, resp_valid}, 32'd0);
        checkOutput("bp_ready_after_handshake", {31'd0, req_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
